// File: rtl/delay_timer.sv
// delay_timer: multi-channel terminal-count delay timer clocked at 2 kHz.
// Each channel has an IDLE/RUN FSM. The channel counts edges from Start and
// pulses o_Done once for a single cycle when the count reaches its terminal
// value tc.
// Optional feature macro: DELAY_TIMER_PERIODIC_EN. When it is defined, a
// per-channel periodic (auto-reload) mode is compiled in and selected by
// i_Mode. When it is undefined, every channel is one-shot and i_Mode is
// ignored.
module delay_timer #(
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned DEFAULT_TC = 4000
) (
  input  logic                      clk_2K,
  input  logic                      i_Reset,
  input  logic [CHANNELS-1:0]       i_Start,
  input  logic [CHANNELS-1:0]       i_Stop,
  input  logic [CHANNELS-1:0]       i_Load,
  input  logic [WIDTH-1:0]          i_LoadVal,
  input  logic [CHANNELS-1:0]       i_Mode,
  output logic [CHANNELS*WIDTH-1:0] o_Count,
  output logic [CHANNELS-1:0]       o_Busy,
  output logic [CHANNELS-1:0]       o_Done
);

  // One extra bit so count+1 never wraps when compared against tc.
  localparam int unsigned      CW       = WIDTH + 1;
  localparam logic [WIDTH-1:0] TC_RESET = WIDTH'(DEFAULT_TC);
  localparam logic [WIDTH-1:0] TC_MIN   = WIDTH'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Shared load value; a zero terminal count is stored as 1.
  logic [WIDTH-1:0] w_load_tc;
  assign w_load_tc = (i_LoadVal == '0) ? TC_MIN : i_LoadVal;

`ifndef DELAY_TIMER_PERIODIC_EN
  // One-shot only build: i_Mode has no effect.
  logic w_unused_mode;
  assign w_unused_mode = ^i_Mode;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_tc;
    logic [WIDTH-1:0] w_tc_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_busy;
    logic             w_periodic;
    logic [CW-1:0]    w_count_inc;
    logic             w_terminal;

`ifdef DELAY_TIMER_PERIODIC_EN
    logic r_mode;
    logic w_mode_nxt;
    assign w_periodic = r_mode;
`else
    assign w_periodic = 1'b0;
`endif

    // Terminal detection on the widened count so full-scale tc cannot wrap.
    assign w_count_inc = CW'(r_count) + CW'(1);
    assign w_terminal  = (w_count_inc >= CW'(r_tc));

    // Next-state logic; priority is Stop, Start, Load, terminal, increment.
    always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_tc_nxt    = r_tc;
      w_done_nxt  = 1'b0;
`ifdef DELAY_TIMER_PERIODIC_EN
      w_mode_nxt  = r_mode;
`endif
      if (i_Stop[g]) begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end else begin
        // Load only in IDLE, so a Start on the same edge uses the new tc.
        if (i_Load[g] && (r_state == S_IDLE)) begin
          w_tc_nxt = w_load_tc;
        end
        if (i_Start[g]) begin
          w_state_nxt = S_RUN;
          w_count_nxt = '0;
`ifdef DELAY_TIMER_PERIODIC_EN
          w_mode_nxt  = i_Mode[g];
`endif
        end else if (r_state == S_RUN) begin
          if (w_terminal) begin
            w_done_nxt = 1'b1;
            if (w_periodic) begin
              w_count_nxt = '0;
            end else begin
              w_count_nxt = r_tc;
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_count_nxt = w_count_inc[WIDTH-1:0];
          end
        end
      end
    end

    // State, count, terminal and output registers.
    always_ff @(posedge clk_2K) begin
      if (i_Reset) begin
        r_state <= S_IDLE;
        r_count <= '0;
        r_tc    <= TC_RESET;
        r_done  <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_count <= w_count_nxt;
        r_tc    <= w_tc_nxt;
        r_done  <= w_done_nxt;
        r_busy  <= (w_state_nxt == S_RUN);
      end
    end

`ifdef DELAY_TIMER_PERIODIC_EN
    // Mode latched on Start; reset returns the channel to one-shot.
    always_ff @(posedge clk_2K) begin
      if (i_Reset) begin
        r_mode <= 1'b0;
      end else begin
        r_mode <= w_mode_nxt;
      end
    end
`endif

    assign o_Count[g*WIDTH +: WIDTH] = r_count;
    assign o_Busy[g]                 = r_busy;
    assign o_Done[g]                 = r_done;
  end

endmodule

// File: tb/tb_delay_timer.sv
// tb_delay_timer: directed and randomized checks of delay_timer against an
// elapsed-edge reference model.
module tb_delay_timer;

  localparam int W   = 12;
  localparam int C   = 2;
  localparam int DEF = 4000;

  logic           clk_2K;
  logic           i_Reset;
  logic [C-1:0]   i_Start;
  logic [C-1:0]   i_Stop;
  logic [C-1:0]   i_Load;
  logic [W-1:0]   i_LoadVal;
  logic [C-1:0]   i_Mode;
  logic [C*W-1:0] o_Count;
  logic [C-1:0]   o_Busy;
  logic [C-1:0]   o_Done;

  int checks   = 0;
  int failures = 0;

  // Reference model: a run is described by its start edge, and the expected
  // count is derived from the number of edges elapsed since that start.
  int edge_n = 0;
  bit m_run  [C];
  int m_t0   [C];
  int m_tc   [C];
  bit m_mode [C];
  int m_hold [C];
  int e_cnt  [C];
  bit e_done [C];
  bit e_busy [C];

  delay_timer #(.WIDTH(W), .CHANNELS(C), .DEFAULT_TC(DEF)) dut (
    .clk_2K   (clk_2K),
    .i_Reset  (i_Reset),
    .i_Start  (i_Start),
    .i_Stop   (i_Stop),
    .i_Load   (i_Load),
    .i_LoadVal(i_LoadVal),
    .i_Mode   (i_Mode),
    .o_Count  (o_Count),
    .o_Busy   (o_Busy),
    .o_Done   (o_Done)
  );

  initial clk_2K = 1'b0;
  always #5 clk_2K = ~clk_2K;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_edge();
    bit prev;
    int d;
    edge_n++;
    for (int c = 0; c < C; c++) begin
      prev = m_run[c];
      if (i_Reset) begin
        m_run[c]  = 1'b0;
        m_hold[c] = 0;
        m_tc[c]   = DEF;
        m_mode[c] = 1'b0;
      end else if (i_Stop[c]) begin
        m_run[c]  = 1'b0;
        m_hold[c] = 0;
      end else begin
        if (!prev && i_Load[c]) m_tc[c] = (i_LoadVal == 0) ? 1 : int'(i_LoadVal);
        if (i_Start[c]) begin
          m_run[c] = 1'b1;
          m_t0[c]  = edge_n;
`ifdef DELAY_TIMER_PERIODIC_EN
          m_mode[c] = i_Mode[c];
`else
          m_mode[c] = 1'b0;
`endif
        end
      end
      e_done[c] = 1'b0;
      if (m_run[c]) begin
        d = edge_n - m_t0[c];
        if (m_mode[c]) begin
          e_cnt[c]  = d % m_tc[c];
          e_done[c] = (d > 0) && (d % m_tc[c] == 0);
        end else if (d >= m_tc[c]) begin
          e_cnt[c]  = m_tc[c];
          e_done[c] = 1'b1;
          m_run[c]  = 1'b0;
          m_hold[c] = m_tc[c];
        end else begin
          e_cnt[c] = d;
        end
      end else begin
        e_cnt[c] = m_hold[c];
      end
      e_busy[c] = m_run[c];
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < C; c++) begin
      chk($sformatf("model_cnt%0d", c), 32'(o_Count[c*W +: W]), 32'(e_cnt[c]));
      chk($sformatf("model_busy%0d", c), 32'(o_Busy[c]), 32'(e_busy[c]));
      chk($sformatf("model_done%0d", c), 32'(o_Done[c]), 32'(e_done[c]));
    end
  endtask

  task automatic step(input logic [C-1:0] st, input logic [C-1:0] sp,
                      input logic [C-1:0] ld, input logic [W-1:0] lv,
                      input logic [C-1:0] md, input logic rst);
    i_Start   = st;
    i_Stop    = sp;
    i_Load    = ld;
    i_LoadVal = lv;
    i_Mode    = md;
    i_Reset   = rst;
    model_edge();
    @(posedge clk_2K);
    #1;
    check_all();
  endtask

  task automatic idle_step();
    step('0, '0, '0, '0, '0, 1'b0);
  endtask

  function automatic logic [31:0] cnt(input int c);
    return 32'(o_Count[c*W +: W]);
  endfunction

  initial begin
    int lat;
    for (int c = 0; c < C; c++) begin
      m_run[c] = 0; m_t0[c] = 0; m_tc[c] = DEF; m_mode[c] = 0; m_hold[c] = 0;
      e_cnt[c] = 0; e_done[c] = 0; e_busy[c] = 0;
    end
    i_Start = '0; i_Stop = '0; i_Load = '0; i_LoadVal = '0; i_Mode = '0; i_Reset = 1'b1;
    #2;

    // Reset state
    step('0, '0, '0, '0, '0, 1'b1);
    step(2'b11, '0, 2'b11, 12'd7, 2'b11, 1'b1);
    chk("rst_count", 32'(o_Count), 32'd0);
    chk("rst_busy", 32'(o_Busy), 32'd0);
    chk("rst_done", 32'(o_Done), 32'd0);

    // Default tc: Start on first edge after reset, done 4000 edges later
    step(2'b01, '0, '0, '0, '0, 1'b0);
    chk("first_start_busy", 32'(o_Busy[0]), 32'd1);
    chk("first_start_cnt", cnt(0), 32'd0);
    lat = 0;
    for (int k = 0; k < 4100; k++) begin
      idle_step();
      lat++;
      if (o_Done[0] === 1'b1) break;
    end
    chk("default_latency", 32'(lat), 32'd4000);
    chk("default_cnt", cnt(0), 32'd4000);
    chk("default_busy", 32'(o_Busy[0]), 32'd0);
    idle_step();
    chk("done_one_cycle", 32'(o_Done[0]), 32'd0);
    chk("hold_tc", cnt(0), 32'd4000);

    // Load 5 on ch1, then Start: counts 0..5, done on fifth edge only
    step('0, '0, 2'b10, 12'd5, '0, 1'b0);
    step(2'b10, '0, '0, '0, '0, 1'b0);
    chk("tc5_cnt0", cnt(1), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      idle_step();
      chk($sformatf("tc5_cnt%0d", k), cnt(1), 32'(k));
      chk($sformatf("tc5_done%0d", k), 32'(o_Done[1]), (k == 5) ? 32'd1 : 32'd0);
    end
    chk("tc5_busy_end", 32'(o_Busy[1]), 32'd0);

    // Load 0 with Start on same edge: tc=1, done one edge later
    step(2'b01, '0, 2'b01, 12'd0, '0, 1'b0);
    chk("tc0_busy", 32'(o_Busy[0]), 32'd1);
    idle_step();
    chk("tc0_done", 32'(o_Done[0]), 32'd1);
    chk("tc0_cnt", cnt(0), 32'd1);

    // Load during RUN is ignored
    step('0, '0, 2'b01, 12'd3, '0, 1'b0);
    step(2'b01, '0, '0, '0, '0, 1'b0);
    step('0, '0, 2'b01, 12'd9, '0, 1'b0);
    idle_step();
    chk("runload_nodone", 32'(o_Done[0]), 32'd0);
    idle_step();
    chk("runload_done", 32'(o_Done[0]), 32'd1);
    chk("runload_cnt", cnt(0), 32'd3);

    // Periodic mode (or single pulse in one-shot build), tc=3 on ch1
    step('0, '0, 2'b10, 12'd3, '0, 1'b0);
    step(2'b10, '0, '0, '0, 2'b10, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      idle_step();
`ifdef DELAY_TIMER_PERIODIC_EN
      chk($sformatf("per_done%0d", k), 32'(o_Done[1]), (k % 3 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("per_cnt%0d", k), cnt(1), 32'(k % 3));
`else
      chk($sformatf("per_done%0d", k), 32'(o_Done[1]), (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("per_cnt%0d", k), cnt(1), (k < 3) ? 32'(k) : 32'd3);
`endif
    end

    // Stop at count 2
    step(2'b01, '0, '0, '0, '0, 1'b0);
    idle_step();
    idle_step();
    chk("pre_stop_cnt", cnt(0), 32'd2);
    step('0, 2'b01, '0, '0, '0, 1'b0);
    chk("stop_cnt", cnt(0), 32'd0);
    chk("stop_busy", 32'(o_Busy[0]), 32'd0);
    chk("stop_done", 32'(o_Done[0]), 32'd0);

    // Start on terminal edge: restart wins
    step(2'b01, '0, '0, '0, '0, 1'b0);
    idle_step();
    idle_step();
    step(2'b01, '0, '0, '0, '0, 1'b0);
    chk("restart_cnt", cnt(0), 32'd0);
    chk("restart_done", 32'(o_Done[0]), 32'd0);
    chk("restart_busy", 32'(o_Busy[0]), 32'd1);
    step('0, 2'b11, '0, '0, '0, 1'b0);

    // Reset with Start active at count 100, tc back to default afterwards
    step('0, '0, 2'b01, 12'd200, '0, 1'b0);
    step(2'b01, '0, '0, '0, '0, 1'b0);
    for (int k = 0; k < 100; k++) idle_step();
    chk("pre_rst_cnt", cnt(0), 32'd100);
    step(2'b11, '0, '0, '0, '0, 1'b1);
    chk("midrst_count", 32'(o_Count), 32'd0);
    chk("midrst_busy", 32'(o_Busy), 32'd0);
    chk("midrst_done", 32'(o_Done), 32'd0);
    step(2'b01, '0, '0, '0, '0, 1'b0);
    lat = 0;
    for (int k = 0; k < 4100; k++) begin
      idle_step();
      lat++;
      if (o_Done[0] === 1'b1) break;
    end
    chk("post_rst_latency", 32'(lat), 32'd4000);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      logic [C-1:0] st, sp, ld, md;
      logic [W-1:0] lv;
      logic rst;
      for (int c = 0; c < C; c++) begin
        st[c] = ($urandom_range(0, 19) == 0);
        sp[c] = ($urandom_range(0, 39) == 0);
        ld[c] = ($urandom_range(0, 9) == 0);
        md[c] = 1'($urandom_range(0, 1));
      end
      lv  = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
      rst = ($urandom_range(0, 499) == 0);
      step(st, sp, ld, lv, md, rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delay_timer.md
DELAY_TIMER -- requirements
Module: delay_timer

Interface
REQ-001 SHALL provide parameter WIDTH, default 12, meaning the bit width of each channel counter and terminal value.
REQ-002 SHALL provide parameter CHANNELS, default 2, meaning the number of independent timer channels.
REQ-003 SHALL provide parameter DEFAULT_TC, default 4000, meaning the terminal count loaded at reset (2 s at 2 kHz); it SHALL be 1..2**WIDTH-1.
REQ-004 SHALL have port clk_2K, input, 1 bit: the single 2 kHz clock; all logic is on its rising edge.
REQ-005 SHALL have port i_Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_Start, input, CHANNELS bits: per-channel start or restart request, level-sampled each edge.
REQ-007 SHALL have port i_Stop, input, CHANNELS bits: per-channel abort request.
REQ-008 SHALL have port i_Load, input, CHANNELS bits: per-channel terminal-count load strobe.
REQ-009 SHALL have port i_LoadVal, input, WIDTH bits: the terminal value shared by all channels.
REQ-010 SHALL have port i_Mode, input, CHANNELS bits: 1 selects periodic mode, 0 selects one-shot mode.
REQ-011 SHALL have port o_Count, output, CHANNELS*WIDTH bits: the channel counts, with channel n at bits [n*WIDTH +: WIDTH].
REQ-012 SHALL have port o_Busy, output, CHANNELS bits: the channel is in the RUN state.
REQ-013 SHALL have port o_Done, output, CHANNELS bits: a one-cycle terminal-count pulse.

Function
REQ-014 All outputs SHALL be registered, and each channel SHALL have its own two-state FSM (IDLE, RUN), count register, terminal register tc, and latched mode.
REQ-015 Per-channel priority each edge SHALL be: i_Stop, then i_Start, then i_Load, then terminal, then increment.
REQ-016 In any state, i_Stop SHALL set count=0, set state IDLE, and hold o_Done=0.
REQ-017 i_Start without i_Stop SHALL set count=0, set state RUN, and latch i_Mode; it restarts a channel that is already in RUN.
REQ-018 In IDLE, i_Load SHALL set tc=i_LoadVal, and a value of 0 SHALL be stored as 1.
REQ-019 In RUN, i_Load SHALL be ignored.
REQ-020 When i_Load and i_Start are both asserted in IDLE, the new tc SHALL apply to the run being started.
REQ-021 In RUN with no request and count+1 < tc, the channel SHALL increment count by 1.
REQ-022 In RUN with no request and count+1 == tc, the channel SHALL assert o_Done=1 for that cycle only.
REQ-023 On that terminal edge in one-shot mode, the channel SHALL set count=tc and state IDLE; count holds tc until the next Start or Stop.
REQ-024 On that terminal edge in periodic mode, the channel SHALL set count=0 and stay in RUN.
REQ-025 Terminal latency SHALL be exactly tc edges after the Start edge; with tc=1, o_Done SHALL assert on the first edge after Start.
REQ-026 When Start coincides with the terminal edge, the restart SHALL win and o_Done SHALL stay 0.
REQ-027 Count SHALL never exceed tc; WIDTH arithmetic SHALL not wrap.
REQ-028 In IDLE, count SHALL hold its value and o_Done SHALL be 0.
REQ-029 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.

Reset
REQ-030 While i_Reset=1 at an edge, every channel SHALL set count=0, tc=DEFAULT_TC, mode=0, state IDLE, o_Busy=0 and o_Done=0, regardless of other inputs.
REQ-031 Reset asserted mid-run SHALL abort the run with no o_Done pulse.
REQ-032 The first request SHALL be accepted on the first edge after i_Reset deasserts.

Configuration
REQ-033 Macro DELAY_TIMER_PERIODIC_EN, when defined, SHALL compile in periodic mode exactly as REQ-024 specifies.
REQ-034 When DELAY_TIMER_PERIODIC_EN is undefined, i_Mode SHALL be ignored, all channels SHALL be one-shot only, and no mode register SHALL exist.

Verification
REQ-035 Reset, then Start ch0 with default tc -> o_Done[0] pulses exactly 4000 edges later; o_Count ch0 holds 4000; o_Busy[0]=0.
REQ-036 Load 5 on ch1 in IDLE, then Start -> counts 0,1,2,3,4,5 on successive edges; o_Done[1] asserts on the fifth edge only.
REQ-037 Load 0 then Start -> o_Done asserts one edge later; a Load of 9 during RUN leaves tc unchanged.
REQ-038 With DELAY_TIMER_PERIODIC_EN, i_Mode=1 and tc=3 -> o_Done pulses every 3 edges with count sequence 0,1,2,0,...; without the macro -> a single pulse.
REQ-039 Stop at count 2 -> count 0 and o_Busy 0 with no o_Done; Start on the terminal edge -> count 0 with no o_Done.
REQ-040 i_Reset asserted with Start active at count 100 -> all outputs 0, and tc returns to 4000 after deassertion.
